// File: rtl/bcd_pkg.sv
// Shared BCD constants and single-digit increment/decrement helpers.
package bcd_pkg;

  localparam int         BCD_W         = 4;
  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  localparam logic [3:0] BCD_ZERO      = 4'd0;

  // Returns {next_digit, carry}; the digit only moves when carry-in is set.
  function automatic logic [BCD_W:0] bcd_digit_inc(input logic [BCD_W-1:0] digit,
                                                   input logic cin);
    logic [BCD_W:0] res;
    if (!cin) begin
      res = {digit, 1'b0};
    end else if (digit == BCD_MAX_DIGIT) begin
      res = {BCD_ZERO, 1'b1};
    end else begin
      res = {digit + 4'd1, 1'b0};
    end
    return res;
  endfunction

  // Returns {next_digit, borrow}; the digit only moves when borrow-in is set.
  function automatic logic [BCD_W:0] bcd_digit_dec(input logic [BCD_W-1:0] digit,
                                                   input logic bin);
    logic [BCD_W:0] res;
    if (!bin) begin
      res = {digit, 1'b0};
    end else if (digit == BCD_ZERO) begin
      res = {BCD_MAX_DIGIT, 1'b1};
    end else begin
      res = {digit - 4'd1, 1'b0};
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_edge_rise.sv
// Two-flop synchroniser plus previous-value flop; emits a one-clock pulse
// per rising edge of an asynchronous level. All flops reset to 1 so a level
// already high at reset release is not mistaken for a fresh edge.
module sync_edge_rise (
  input  logic clk,
  input  logic rst_a_n,
  input  logic d_in,
  output logic rise_pulse
);

  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;

  // Next-state of the shift chain: input -> s1 -> s2 -> s3.
  always_comb begin
    s1_d = d_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  // Chain registers, forced high on reset.
  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign rise_pulse = s2_q & ~s3_q;

endmodule

// File: rtl/bcd_updown_counter.sv
// Packed BCD up/down counter driven by synchronised button edges, with
// wrap-around and one-cycle carry/borrow pulses.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int N_DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    rst_a_n,
  input  logic                    up_in,
  input  logic                    down_in,
  input  logic                    clr_in,
  output logic [4*N_DIGITS-1:0]   bcd_out,
  output logic                    carry_out,
  output logic                    borrow_out
);

  localparam int CW = BCD_W * N_DIGITS;

  logic up_pulse, down_pulse, clr_pulse;

  sync_edge_rise u_sync_up (
    .clk        (clk),
    .rst_a_n    (rst_a_n),
    .d_in       (up_in),
    .rise_pulse (up_pulse)
  );

  sync_edge_rise u_sync_down (
    .clk        (clk),
    .rst_a_n    (rst_a_n),
    .d_in       (down_in),
    .rise_pulse (down_pulse)
  );

  sync_edge_rise u_sync_clr (
    .clk        (clk),
    .rst_a_n    (rst_a_n),
    .d_in       (clr_in),
    .rise_pulse (clr_pulse)
  );

  logic [CW-1:0]     count_q, count_d;
  logic              carry_q, carry_d;
  logic              borrow_q, borrow_d;
  logic [CW-1:0]     inc_val, dec_val;
  logic [N_DIGITS:0] inc_c, dec_b;

  // The units digit always steps; higher digits step only on a ripple.
  assign inc_c[0] = 1'b1;
  assign dec_b[0] = 1'b1;

  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
    assign {inc_val[gi*BCD_W +: BCD_W], inc_c[gi+1]} =
      bcd_digit_inc(count_q[gi*BCD_W +: BCD_W], inc_c[gi]);
    assign {dec_val[gi*BCD_W +: BCD_W], dec_b[gi+1]} =
      bcd_digit_dec(count_q[gi*BCD_W +: BCD_W], dec_b[gi]);
  end

  // Select the next count: clear beats everything, up+down cancel out.
  always_comb begin
    count_d  = count_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    if (clr_pulse) begin
      count_d = '0;
    end else if (up_pulse && !down_pulse) begin
      count_d = inc_val;
      carry_d = inc_c[N_DIGITS];
    end else if (down_pulse && !up_pulse) begin
      count_d  = dec_val;
      borrow_d = dec_b[N_DIGITS];
    end
  end

  // Count and wrap-pulse registers.
  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      count_q  <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end
  end

  assign bcd_out    = count_q;
  assign carry_out  = carry_q;
  assign borrow_out = borrow_q;

endmodule
